// File: rtl/snake_pkg.sv
// Shared definitions for the snake playfield tile memory.
// Provides: playfield geometry, bus widths, cell byte layout, tag codes, FSM states.
// No ports; imported by board_mem, board_mem_if and tile_bram users.
package snake_pkg;

   localparam int COLS   = 32;
   localparam int ROWS   = 24;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;

   // Upper five bits of a cell byte; codes above WALL are reserved.
   typedef enum logic [4:0] {
      TAG_EMPTY = 5'd0,
      TAG_SNAKE = 5'd1,
      TAG_FOOD  = 5'd2,
      TAG_WALL  = 5'd3
   } tag_e;

   typedef struct packed {
      logic [4:0] tag;
      logic [2:0] rgb;
   } cell_t;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } bm_state_e;

endpackage

// File: rtl/board_mem_if.sv
// Bus bundle between the tile memory and its two clients (VGA fetch, game engine).
// Ports: VGA read (re/raddr/rdata), game read (g_re/g_addr/g_rdata), game write
// (we/waddr/wdata), clear control (clear_req/busy) and the write-reject pulse (wr_drop).
interface board_mem_if;
   import snake_pkg::*;

   logic              re;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;
   logic              g_re;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_rdata;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              clear_req;
   logic              busy;
   logic              wr_drop;

   // Clients drive requests and observe data/status.
   modport master (
      output re, raddr, g_re, g_addr, we, waddr, wdata, clear_req,
      input  rdata, g_rdata, busy, wr_drop
   );

   // The memory block answers requests.
   modport slave (
      input  re, raddr, g_re, g_addr, we, waddr, wdata, clear_req,
      output rdata, g_rdata, busy, wr_drop
   );

endinterface

// File: rtl/tile_bram.sv
// Purpose: 1W1R read-first RAM with a registered, enable-gated output.
// Latency: read data 1 cycle after re; a write is visible to a read issued the next cycle.
// Backpressure: none; always accepts a write and a read every cycle.
// Ports: clk, rst_n (output register only), we/waddr/wdata, re/raddr, rdata.
module tile_bram #(
   parameter int DEPTH = 768,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] rdata_d;

   // The array is sampled before this edge's write lands, giving read-first
   // behaviour on a same-address collision.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // Storage carries no reset; contents are rebuilt by the owner's clear sweep.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/board_mem.sv
// Purpose: snake playfield tile memory, one read port for VGA and one for the game, with a self-clearing sweep.
// Latency: reads 1 cycle; writes visible next cycle; sweep lasts CELLS cycles after reset release or clear_req.
// Backpressure: none; writes during a sweep or to addresses >= CELLS are dropped and flagged on wr_drop one cycle later.
// Ports: clk, reset (async, active-low), bus (board_mem_if.slave).
module board_mem
   import snake_pkg::*;
#(
   parameter int COLS  = snake_pkg::COLS,
   parameter int ROWS  = snake_pkg::ROWS,
   parameter int CELLS = COLS * ROWS
) (
   input  logic        clk,
   input  logic        reset,
   board_mem_if.slave  bus
);

   localparam logic [ADDR_W:0]   CELLS_L  = (ADDR_W+1)'(CELLS);
   localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(CELLS - 1);
   localparam cell_t             CLR_CELL = '{tag: TAG_EMPTY, rgb: 3'b000};

   bm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              busy_q, busy_d;
   logic              wr_drop_q, wr_drop_d;
   // Zero-force flags travel alongside the RAM output registers so that an
   // out-of-range or mid-sweep read yields 0 without touching the array, and
   // the zero is held just like real data while the enable stays low.
   logic              v_zero_q, v_zero_d;
   logic              g_zero_q, g_zero_d;

   logic              clearing;
   logic              w_ok;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic              v_force, g_force;
   logic [DATA_W-1:0] v_rdata, g_rdata_raw;

   always_comb begin
      clearing  = (state_q == ST_CLEAR);

      // A clear request in the same cycle wins over the write.
      w_ok      = bus.we && !clearing && !bus.clear_req &&
                  ({1'b0, bus.waddr} < CELLS_L);
      wr_drop_d = bus.we && !w_ok;

      ram_we    = clearing || w_ok;
      ram_waddr = clearing ? clr_cnt_q : bus.waddr;
      ram_wdata = clearing ? CLR_CELL  : bus.wdata;

      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == LAST) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: begin
            if (bus.clear_req) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
      endcase
      busy_d    = (state_d == ST_CLEAR);

      v_force   = clearing || ({1'b0, bus.raddr}  >= CELLS_L);
      g_force   = clearing || ({1'b0, bus.g_addr} >= CELLS_L);
      v_zero_d  = bus.re   ? v_force : v_zero_q;
      g_zero_d  = bus.g_re ? g_force : g_zero_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
         wr_drop_q <= 1'b0;
         v_zero_q  <= 1'b1;
         g_zero_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
         wr_drop_q <= wr_drop_d;
         v_zero_q  <= v_zero_d;
         g_zero_q  <= g_zero_d;
      end
   end

   tile_bram #(.DEPTH(CELLS), .AW(ADDR_W), .DW(DATA_W)) u_vga_ram (
      .clk   (clk),
      .rst_n (reset),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (bus.re && !v_force),
      .raddr (bus.raddr),
      .rdata (v_rdata)
   );

   tile_bram #(.DEPTH(CELLS), .AW(ADDR_W), .DW(DATA_W)) u_game_ram (
      .clk   (clk),
      .rst_n (reset),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (bus.g_re && !g_force),
      .raddr (bus.g_addr),
      .rdata (g_rdata_raw)
   );

   assign bus.rdata   = v_zero_q ? '0 : v_rdata;
   assign bus.g_rdata = g_zero_q ? '0 : g_rdata_raw;
   assign bus.busy    = busy_q;
   assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_board_mem.sv
// Bench for board_mem: reset sweep length, read/write vector table, clear during
// traffic, and asynchronous reset both in IDLE and mid-sweep.
module tb_board_mem;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   board_mem_if bus ();

   board_mem dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [9:0] waddr;
      logic [7:0] wdata;
      logic       re;
      logic [9:0] raddr;
      logic       g_re;
      logic [9:0] g_addr;
      logic [7:0] exp_r;
      logic [7:0] exp_g;
      logic       exp_drop;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.re        = 1'b0;
      bus.raddr     = '0;
      bus.g_re      = 1'b0;
      bus.g_addr    = '0;
      bus.we        = 1'b0;
      bus.waddr     = '0;
      bus.wdata     = '0;
      bus.clear_req = 1'b0;
   endtask

   // Counts negedges with busy high, starting at the current negedge.
   task automatic measure_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   // One read cycle on both ports, checked at the following negedge.
   task automatic read_both(input logic [9:0] a, input logic [9:0] ga,
                            input logic [7:0] er, input logic [7:0] eg, input string tag);
      idle_inputs();
      bus.re     = 1'b1;
      bus.raddr  = a;
      bus.g_re   = 1'b1;
      bus.g_addr = ga;
      @(negedge clk);
      check({tag, "_rdata"},   32'(bus.rdata),   32'(er));
      check({tag, "_g_rdata"}, 32'(bus.g_rdata), 32'(eg));
      idle_inputs();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int m;
      total = 0;
      bad   = 0;

      //              we    waddr    wdata  re    raddr     g_re  g_addr    exp_r  exp_g  drop
      vecs[0]  = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd0,    1'b1, 10'd767,  8'h00, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd383,  1'b0, 10'd0,    8'h00, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 10'd100, 8'h0C, 1'b0, 10'd0,    1'b0, 10'd0,    8'h00, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd100,  1'b1, 10'd100,  8'h0C, 8'h0C, 1'b0};
      vecs[4]  = '{1'b1, 10'd5,   8'h11, 1'b0, 10'd0,    1'b0, 10'd0,    8'h0C, 8'h0C, 1'b0};
      vecs[5]  = '{1'b1, 10'd5,   8'h22, 1'b1, 10'd5,    1'b1, 10'd5,    8'h11, 8'h11, 1'b0};
      vecs[6]  = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd5,    1'b0, 10'd0,    8'h22, 8'h11, 1'b0};
      vecs[7]  = '{1'b1, 10'd800, 8'hFF, 1'b1, 10'd800,  1'b0, 10'd0,    8'h00, 8'h11, 1'b1};
      vecs[8]  = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0,    1'b1, 10'd800,  8'h00, 8'h00, 1'b0};
      vecs[9]  = '{1'b1, 10'd767, 8'h1B, 1'b1, 10'd767,  1'b1, 10'd100,  8'h00, 8'h0C, 1'b0};
      vecs[10] = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd767,  1'b1, 10'd767,  8'h1B, 8'h1B, 1'b0};
      vecs[11] = '{1'b1, 10'd768, 8'h33, 1'b1, 10'd1023, 1'b0, 10'd0,    8'h00, 8'h1B, 1'b1};
      vecs[12] = '{1'b1, 10'd0,   8'h13, 1'b1, 10'd0,    1'b0, 10'd0,    8'h00, 8'h1B, 1'b0};
      vecs[13] = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd0,    1'b1, 10'd0,    8'h13, 8'h13, 1'b0};
      vecs[14] = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0,    1'b0, 10'd0,    8'h13, 8'h13, 1'b0};

      // Reset values and the power-on sweep.
      idle_inputs();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdata",   32'(bus.rdata),   32'h0);
      check("rst_g_rdata", 32'(bus.g_rdata), 32'h0);
      check("rst_busy",    32'(bus.busy),    32'h1);
      check("rst_wr_drop", 32'(bus.wr_drop), 32'h0);
      reset = 1'b1;
      measure_busy(n);
      check("init_sweep_len", 32'(n), 32'd768);
      read_both(10'd0,   10'd383, 8'h00, 8'h00, "init_a");
      read_both(10'd767, 10'd0,   8'h00, 8'h00, "init_b");
      read_both(10'd383, 10'd767, 8'h00, 8'h00, "init_c");

      // Vector table in IDLE.
      for (int i = 0; i < 15; i++) begin
         bus.we     = vecs[i].we;
         bus.waddr  = vecs[i].waddr;
         bus.wdata  = vecs[i].wdata;
         bus.re     = vecs[i].re;
         bus.raddr  = vecs[i].raddr;
         bus.g_re   = vecs[i].g_re;
         bus.g_addr = vecs[i].g_addr;
         @(negedge clk);
         check($sformatf("vec%0d_rdata", i),   32'(bus.rdata),   32'(vecs[i].exp_r));
         check($sformatf("vec%0d_g_rdata", i), 32'(bus.g_rdata), 32'(vecs[i].exp_g));
         check($sformatf("vec%0d_wr_drop", i), 32'(bus.wr_drop), 32'(vecs[i].exp_drop));
      end
      idle_inputs();

      // clear_req together with a write; traffic and a second request during the sweep.
      bus.we = 1'b1; bus.waddr = 10'd10; bus.wdata = 8'h0A;
      @(negedge clk);
      bus.we = 1'b1; bus.waddr = 10'd20; bus.wdata = 8'h55; bus.clear_req = 1'b1;
      @(negedge clk);
      check("clr_req_wr_drop", 32'(bus.wr_drop), 32'h1);
      check("clr_req_busy",    32'(bus.busy),    32'h1);
      n = (bus.busy === 1'b1) ? 1 : 0;
      bus.clear_req = 1'b1;
      bus.we = 1'b1; bus.waddr = 10'd100; bus.wdata = 8'h77;
      bus.re = 1'b1; bus.raddr = 10'd100; bus.g_re = 1'b1; bus.g_addr = 10'd100;
      @(negedge clk);
      check("sweep_rdata",   32'(bus.rdata),   32'h0);
      check("sweep_g_rdata", 32'(bus.g_rdata), 32'h0);
      check("sweep_wr_drop", 32'(bus.wr_drop), 32'h1);
      if (bus.busy === 1'b1) n++;
      idle_inputs();
      @(negedge clk);
      measure_busy(m);
      check("clear_sweep_len", 32'(n + m), 32'd768);
      read_both(10'd10,  10'd20,  8'h00, 8'h00, "post_clr_a");
      read_both(10'd100, 10'd100, 8'h00, 8'h00, "post_clr_b");

      // Asynchronous reset while IDLE outputs are non-zero.
      bus.we = 1'b1; bus.waddr = 10'd100; bus.wdata = 8'h0C;
      @(negedge clk);
      bus.we = 1'b1; bus.waddr = 10'd900; bus.wdata = 8'h01;
      bus.re = 1'b1; bus.raddr = 10'd100; bus.g_re = 1'b1; bus.g_addr = 10'd100;
      @(negedge clk);
      check("pre_rst_rdata",   32'(bus.rdata),   32'h0C);
      check("pre_rst_wr_drop", 32'(bus.wr_drop), 32'h1);
      idle_inputs();
      reset = 1'b0;
      #1;
      check("arst_rdata",   32'(bus.rdata),   32'h0);
      check("arst_g_rdata", 32'(bus.g_rdata), 32'h0);
      check("arst_busy",    32'(bus.busy),    32'h1);
      check("arst_wr_drop", 32'(bus.wr_drop), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      measure_busy(n);
      check("rerun_sweep_len", 32'(n), 32'd768);
      read_both(10'd100, 10'd100, 8'h00, 8'h00, "post_arst");

      // Reset at sweep cycle 300 with a drop pulse pending.
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (299) @(negedge clk);
      bus.we = 1'b1; bus.waddr = 10'd3; bus.wdata = 8'h09;
      @(negedge clk);
      idle_inputs();
      check("mid_sweep_busy",    32'(bus.busy),    32'h1);
      check("mid_sweep_wr_drop", 32'(bus.wr_drop), 32'h1);
      reset = 1'b0;
      #1;
      check("mid_rst_wr_drop", 32'(bus.wr_drop), 32'h0);
      check("mid_rst_busy",    32'(bus.busy),    32'h1);
      check("mid_rst_rdata",   32'(bus.rdata),   32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      measure_busy(n);
      check("restart_sweep_len", 32'(n), 32'd768);
      bus.we = 1'b1; bus.waddr = 10'd3; bus.wdata = 8'h1A;
      @(negedge clk);
      read_both(10'd3, 10'd3, 8'h1A, 8'h1A, "post_restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_mem.md
# board_mem

Tile-state memory for the snake playfield. It sits directly upstream of the VGA stage: that stage issues `re`/`raddr` and consumes the returned 8-bit cell byte as `state_in`. The game engine writes cells and reads them back for collision checks. The block also runs a self-clearing sweep after reset and on request.

## Interface
Parameters:
- `COLS`, default 32: playfield width in tiles.
- `ROWS`, default 24: playfield height in tiles.
- `CELLS`, default `COLS*ROWS` = 768: number of valid addresses.

Ports:
- `clk` in 1: the single system clock.
- `reset` in 1: asynchronous, active-low.
- `re` in 1: VGA read enable.
- `raddr` in 10: VGA read address, tile index `row*COLS+col`.
- `rdata` out 8: VGA read data, which feeds `state_in`.
- `g_re` in 1: game read enable.
- `g_addr` in 10: game read address.
- `g_rdata` out 8: game read data.
- `we` in 1: game write enable.
- `waddr` in 10: game write address.
- `wdata` in 8: game write data.
- `clear_req` in 1: single-cycle pulse that requests a full clear.
- `busy` out 1: high while a clear sweep runs.
- `wr_drop` out 1: one-cycle pulse when a write is rejected.

## Operation
- Cell byte layout:
  - bits [2:0] are RGB colour.
  - bits [7:3] are the tag: 0 = EMPTY, 1 = SNAKE, 2 = FOOD, 3 = WALL; other values are reserved.
- Storage is two identical 1W1R arrays, one per read port.
  - Every accepted write goes to both arrays in the same cycle.
- FSM states and transitions:
  - CLEAR → IDLE after the sweep writes cell `CELLS-1`.
  - IDLE → CLEAR on `clear_req`.
  - Reset release always enters CLEAR with the sweep counter at 0.
- CLEAR:
  - Each cycle, write 8'h00 to address `clr_cnt` in both arrays, then increment `clr_cnt`.
  - The sweep takes exactly `CELLS` cycles.
  - `busy` is 1 for the whole sweep.
  - Game writes are dropped and `wr_drop` pulses for each one.
  - `rdata` and `g_rdata` are forced to 0 on any read.
  - `clear_req` is ignored; the sweep does not restart.
- IDLE:
  - `we` writes `wdata` to `waddr` in both arrays.
  - If `waddr >= CELLS`, the write is dropped and `wr_drop` pulses.
- Reads:
  - Registered; data appears one cycle after the enable.
  - When the enable is low, the read-data register holds its value.
  - An address `>= CELLS` returns 8'h00 with no array access.
- Same-cycle read and write to the same address: the read returns the old data (read-first).
- `clear_req` and `we` in the same IDLE cycle: the write is dropped with a `wr_drop` pulse, and CLEAR starts next cycle.
- `reset` asserted mid-sweep or mid-write:
  - Outputs reset immediately.
  - Array contents are undefined, which is why the sweep reruns on release.

## Timing
- Reset values:
  - `rdata` = 0, `g_rdata` = 0.
  - `busy` = 1, because CLEAR is entered on release.
  - `wr_drop` = 0.
  - `clr_cnt` = 0.
- Read latency: 1 cycle on both ports, which matches the VGA stage's one-cycle fetch ahead of `updateoutput`.
- Write latency: the data is visible to a read issued in the next cycle.
- After `clear_req` is sampled in IDLE:
  - `busy` rises on the next edge.
  - It stays high for `CELLS` cycles, then falls.
- `clr_cnt` is 10 bits. It compares against `CELLS-1` and never wraps past it.
- `wr_drop` is registered, so it pulses one cycle after the rejected `we`.

## Structure
- Package `snake_pkg` holds:
  - `COLS`, `ROWS`, `CELLS`.
  - The `cell_t` packed struct (`tag[4:0]`, `rgb[2:0]`).
  - The `tag_e` enum.
  - The `bm_state_e` enum (CLEAR, IDLE).
- Sub-module `tile_bram`: a parameterised 1W1R, read-first, registered-output RAM with read enable. It is instantiated twice.
- `board_mem` holds:
  - The FSM and sweep counter.
  - Address range checks.
  - Zero-forcing of the read outputs.
  - `wr_drop` generation.

## Test plan
- Reset sweep: release `reset`.
  - `busy` = 1 for 768 cycles, then 0.
  - Afterwards, reads of addresses 0, 383 and 767 return 8'h00 on both ports.
- Write/read: in IDLE, write 8'h0C to 100.
  - Next cycle, `re` with `raddr`=100 gives `rdata`=8'h0C one cycle later.
  - Also `g_re` with `g_addr`=100 gives `g_rdata`=8'h0C.
- Read-first collision: address 5 holds 8'h11. In the same cycle, write 8'h22 to 5 and read 5.
  - `rdata` = 8'h11.
  - The following read returns 8'h22.
- Out of range: write to 800 → `wr_drop` pulses one cycle later. A read of 800 returns 8'h00.
- `clear_req` during traffic: write 8'h0A to 10, then pulse `clear_req` together with a write to 20.
  - That write is dropped and `wr_drop` pulses.
  - `busy` is high for 768 cycles.
  - Afterwards, addresses 10 and 20 read 8'h00.
- Reset mid-sweep: assert `reset` at sweep cycle 300.
  - Outputs go to reset values at once.
  - On release, the sweep restarts from 0 and lasts a full 768 cycles.
